// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard detection, operand forwarding and pipeline control for the 5-stage
// MIPS core. A registered shadow of the EX, MEM and WB stages (valid, dest,
// regwrite, memread, memwrite, plus rs/rt for EX) advances in lockstep with
// the pipeline registers. The shadow drives stall/bubble/flush/freeze and the
// forwarding selects combinationally in the same cycle.
//
// Optional feature: define HAZ_PERF_CNT_EN to build the stall/flush/freeze
// performance counters. When it is undefined, the counter outputs are tied
// to zero and no counter flops exist.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   id_rs_i, id_rt_i       source registers of the instruction in IF/ID
//   id_dest_i              resolved destination of the ID instruction
//   id_regwrite_i,
//   id_memread_i,
//   id_memwrite_i          decoded controls of the ID instruction
//   id_branch_i            ID instruction compares rs/rt in ID
//   id_taken_i             branch taken or jump resolved in ID
//   dmem_ready_i           data memory has completed the MEM access
//   stall_o                hold PC and IF/ID
//   bubble_o               zero the controls entering ID/EX
//   flush_o                clear IF/ID
//   freeze_o               hold every pipeline register
//   fwd_a_o, fwd_b_o       EX operand select (00 RF, 01 WB, 10 EX/MEM ALU)
//   fwd_id_a_o, fwd_id_b_o select EX/MEM ALU result for the ID compare
//   stall_cnt_o,
//   flush_cnt_o,
//   freeze_cnt_o           perf counters (zero unless HAZ_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_dest_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_branch_i,
  input  logic              id_taken_i,
  input  logic              dmem_ready_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic              freeze_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              fwd_id_a_o,
  output logic              fwd_id_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  freeze_cnt_o
);

  // Shadow entries: p0 = EX, p1 = MEM, p2 = WB.
  logic              vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [REG_AW-1:0] dest_p0_q, dest_p0_d, dest_p1_q, dest_p1_d, dest_p2_q, dest_p2_d;
  logic              rw_p0_q, rw_p0_d, rw_p1_q, rw_p1_d, rw_p2_q, rw_p2_d;
  logic              mr_p0_q, mr_p0_d, mr_p1_q, mr_p1_d, mr_p2_q, mr_p2_d;
  logic              mw_p0_q, mw_p0_d, mw_p1_q, mw_p1_d, mw_p2_q, mw_p2_d;
  logic [REG_AW-1:0] rs_p0_q, rs_p0_d, rt_p0_q, rt_p0_d;

  logic wr_p0, wr_p1, wr_p2;
  logic freeze_raw, lu_stall, br_stall, stall_raw, bubble_raw;
  logic unused_wb_mem_ctrl;

  // WB memory controls are kept for a complete shadow but never consulted.
  assign unused_wb_mem_ctrl = ^{mr_p2_q, mw_p2_q};

  // A writer never matches register 0.
  assign wr_p0 = vld_p0_q && rw_p0_q && (dest_p0_q != '0);
  assign wr_p1 = vld_p1_q && rw_p1_q && (dest_p1_q != '0);
  assign wr_p2 = vld_p2_q && rw_p2_q && (dest_p2_q != '0);

  assign freeze_raw = vld_p1_q && (mr_p1_q || mw_p1_q) && !dmem_ready_i;
  assign lu_stall   = wr_p0 && mr_p0_q &&
                      ((dest_p0_q == id_rs_i) || (dest_p0_q == id_rt_i));
  // A branch compares in ID, so an ALU result still in EX is one cycle too
  // late, and a load in MEM is not available until it reaches WB.
  assign br_stall   = id_branch_i &&
                      ((wr_p0 && ((dest_p0_q == id_rs_i) || (dest_p0_q == id_rt_i))) ||
                       (wr_p1 && mr_p1_q &&
                        ((dest_p1_q == id_rs_i) || (dest_p1_q == id_rt_i))));
  assign stall_raw  = freeze_raw || lu_stall || br_stall;
  assign bubble_raw = !freeze_raw && (lu_stall || br_stall);

  always_comb begin
    stall_o    = 1'b0;
    bubble_o   = 1'b0;
    flush_o    = 1'b0;
    freeze_o   = 1'b0;
    fwd_a_o    = 2'b00;
    fwd_b_o    = 2'b00;
    fwd_id_a_o = 1'b0;
    fwd_id_b_o = 1'b0;
    if (!rst_i) begin
      stall_o  = stall_raw;
      bubble_o = bubble_raw;
      flush_o  = id_taken_i && !stall_raw;
      freeze_o = freeze_raw;
      // MEM (younger result) takes priority over WB.
      if (wr_p1 && !mr_p1_q && (dest_p1_q == rs_p0_q))      fwd_a_o = 2'b10;
      else if (wr_p2 && (dest_p2_q == rs_p0_q))             fwd_a_o = 2'b01;
      if (wr_p1 && !mr_p1_q && (dest_p1_q == rt_p0_q))      fwd_b_o = 2'b10;
      else if (wr_p2 && (dest_p2_q == rt_p0_q))             fwd_b_o = 2'b01;
      fwd_id_a_o = id_branch_i && wr_p1 && !mr_p1_q && (dest_p1_q == id_rs_i);
      fwd_id_b_o = id_branch_i && wr_p1 && !mr_p1_q && (dest_p1_q == id_rt_i);
    end
  end

  always_comb begin
    vld_p0_d = vld_p0_q; dest_p0_d = dest_p0_q; rw_p0_d = rw_p0_q;
    mr_p0_d  = mr_p0_q;  mw_p0_d   = mw_p0_q;   rs_p0_d = rs_p0_q; rt_p0_d = rt_p0_q;
    vld_p1_d = vld_p1_q; dest_p1_d = dest_p1_q; rw_p1_d = rw_p1_q;
    mr_p1_d  = mr_p1_q;  mw_p1_d   = mw_p1_q;
    vld_p2_d = vld_p2_q; dest_p2_d = dest_p2_q; rw_p2_d = rw_p2_q;
    mr_p2_d  = mr_p2_q;  mw_p2_d   = mw_p2_q;
    if (!freeze_raw) begin
      vld_p2_d = vld_p1_q; dest_p2_d = dest_p1_q; rw_p2_d = rw_p1_q;
      mr_p2_d  = mr_p1_q;  mw_p2_d   = mw_p1_q;
      vld_p1_d = vld_p0_q; dest_p1_d = dest_p0_q; rw_p1_d = rw_p0_q;
      mr_p1_d  = mr_p0_q;  mw_p1_d   = mw_p0_q;
      if (bubble_raw) begin
        // All-zero bubble: rs/rt of 0 can never pick up a forward.
        vld_p0_d = 1'b0; dest_p0_d = '0; rw_p0_d = 1'b0;
        mr_p0_d  = 1'b0; mw_p0_d   = 1'b0; rs_p0_d = '0; rt_p0_d = '0;
      end else begin
        vld_p0_d = 1'b1;          dest_p0_d = id_dest_i;     rw_p0_d = id_regwrite_i;
        mr_p0_d  = id_memread_i;  mw_p0_d   = id_memwrite_i;
        rs_p0_d  = id_rs_i;       rt_p0_d   = id_rt_i;
      end
    end
  end

  // ---- stage boundary: ID -> EX -> MEM -> WB shadow registers ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clk_i) begin
    dest_p0_q <= dest_p0_d; rw_p0_q <= rw_p0_d; mr_p0_q <= mr_p0_d; mw_p0_q <= mw_p0_d;
    rs_p0_q   <= rs_p0_d;   rt_p0_q <= rt_p0_d;
    dest_p1_q <= dest_p1_d; rw_p1_q <= rw_p1_d; mr_p1_q <= mr_p1_d; mw_p1_q <= mw_p1_d;
    dest_p2_q <= dest_p2_d; rw_p2_q <= rw_p2_d; mr_p2_q <= mr_p2_d; mw_p2_q <= mw_p2_d;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q  + CNT_W'(stall_o);
    flush_cnt_d  = flush_cnt_q  + CNT_W'(flush_o);
    freeze_cnt_d = freeze_cnt_q + CNT_W'(freeze_o);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign freeze_cnt_o = freeze_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign flush_cnt_o  = '0;
  assign freeze_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [4:0]  id_rs_i = '0, id_rt_i = '0, id_dest_i = '0;
  logic        id_regwrite_i = 1'b0, id_memread_i = 1'b0, id_memwrite_i = 1'b0;
  logic        id_branch_i = 1'b0, id_taken_i = 1'b0;
  logic        dmem_ready_i = 1'b1;
  logic        stall_o, bubble_o, flush_o, freeze_o;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic        fwd_id_a_o, fwd_id_b_o;
  logic [31:0] stall_cnt_o, flush_cnt_o, freeze_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  // {stall, bubble, flush, freeze, fwd_a[1:0], fwd_b[1:0], fwd_id_a, fwd_id_b}
  logic [9:0]  obs;
  logic [9:0]  exp_v;
  logic [31:0] exp_cnt;
  assign obs = {stall_o, bubble_o, flush_o, freeze_o, fwd_a_o, fwd_b_o, fwd_id_a_o, fwd_id_b_o};

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_dest_i(id_dest_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_branch_i(id_branch_i),
    .id_taken_i(id_taken_i), .dmem_ready_i(dmem_ready_i),
    .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o), .freeze_o(freeze_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .fwd_id_a_o(fwd_id_a_o), .fwd_id_b_o(fwd_id_b_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .freeze_cnt_o(freeze_cnt_o)
  );

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                        input logic rw, input logic mr, input logic mw,
                        input logic br, input logic tk);
    id_rs_i = rs; id_rt_i = rt; id_dest_i = dest;
    id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = mw;
    id_branch_i = br; id_taken_i = tk;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    nop();
    dmem_ready_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_id(5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    next_cycle();
    #1;
    exp_v = 10'b0000000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_outputs: got %b want %b", obs, exp_v); end
    n_cmp++;
    if ({stall_cnt_o, flush_cnt_o, freeze_cnt_o} !== 96'd0) begin
      n_err++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", stall_cnt_o, flush_cnt_o, freeze_cnt_o);
    end
    next_cycle();
    rst_i = 1'b0;
    set_id(5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // lw $2
    @(negedge clk);
    exp_v = 10'b0000000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_first_cycle: got %b want %b", obs, exp_v); end
    next_cycle();
    set_id(5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add $3,$2,$4
    @(negedge clk);
    exp_v = 10'b1100000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_ex_loaded: got %b want %b", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // lw $2,0($1)
    @(negedge clk);
    exp_v = 10'b0000000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lu_lw_id: got %b want %b", obs, exp_v); end
    next_cycle();
    set_id(5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add $3,$2,$4
    @(negedge clk);
    exp_v = 10'b1100000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lu_stall: got %b want %b", obs, exp_v); end
    next_cycle();
    @(negedge clk);
    exp_v = 10'b0000000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lu_one_cycle: got %b want %b", obs, exp_v); end
    next_cycle();
    nop();
    @(negedge clk);
    exp_v = 10'b0000010000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lu_fwd_wb: got %b want %b", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_alu_fwd();
    do_reset();
    set_id(5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add $2,$1,$1
    next_cycle();
    set_id(5'd2, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // sub $3,$2,$2
    @(negedge clk);
    exp_v = 10'b0000000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL alu_no_stall: got %b want %b", obs, exp_v); end
    next_cycle();
    nop();
    @(negedge clk);
    exp_v = 10'b0000101000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL alu_fwd_mem: got %b want %b", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_fwd_priority();
    do_reset();
    set_id(5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add $2,$1,$1
    next_cycle();
    set_id(5'd3, 5'd4, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add $2,$3,$4
    next_cycle();
    set_id(5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // or $5,$2,$0
    next_cycle();
    nop();
    @(negedge clk);
    exp_v = 10'b0000100000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL fwd_mem_priority: got %b want %b", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_branch_alu();
    do_reset();
    set_id(5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add $2,$1,$1
    next_cycle();
    set_id(5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);   // beq $2,$3 (taken)
    @(negedge clk);
    exp_v = 10'b1100000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL br_alu_stall: got %b want %b", obs, exp_v); end
    next_cycle();
    @(negedge clk);
    exp_v = 10'b0010000010;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL br_alu_fwd_flush: got %b want %b", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_branch_load();
    do_reset();
    set_id(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // lw $2
    next_cycle();
    set_id(5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);   // beq $2,$2 (taken)
    @(negedge clk);
    exp_v = 10'b1100000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL br_ld_stall1: got %b want %b", obs, exp_v); end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL br_ld_stall2: got %b want %b", obs, exp_v); end
    next_cycle();
    @(negedge clk);
    exp_v = 10'b0010000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL br_ld_release: got %b want %b", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_freeze();
    do_reset();
    set_id(5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // lw $2
    next_cycle();
    nop();
    next_cycle();
    dmem_ready_i = 1'b0;
    set_id(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // add $4,$2,$2 with taken held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_v = 10'b1001000000;
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL freeze_cycle%0d: got %b want %b", i, obs, exp_v); end
      next_cycle();
    end
    dmem_ready_i = 1'b1;
    set_id(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exp_v = 10'b0000000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL freeze_release: got %b want %b", obs, exp_v); end
`ifdef HAZ_PERF_CNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    n_cmp++;
    if (freeze_cnt_o !== exp_cnt) begin n_err++; $display("FAIL freeze_cnt: got %0d want %0d", freeze_cnt_o, exp_cnt); end
    next_cycle();
    nop();
    @(negedge clk);
    exp_v = 10'b0000010100;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL freeze_shadow_kept: got %b want %b", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    set_id(5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // lw $2
    next_cycle();
    nop();
    next_cycle();
    dmem_ready_i = 1'b0;
    id_taken_i = 1'b1;
    next_cycle();
    @(negedge clk);
    exp_v = 10'b1001000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rstfz_frozen: got %b want %b", obs, exp_v); end
    #1;
    rst_i = 1'b1;
    #1;
    exp_v = 10'b0000000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rstfz_outputs: got %b want %b", obs, exp_v); end
    n_cmp++;
    if ({stall_cnt_o, flush_cnt_o, freeze_cnt_o} !== 96'd0) begin
      n_err++; $display("FAIL rstfz_counters: got %0d/%0d/%0d want 0/0/0", stall_cnt_o, flush_cnt_o, freeze_cnt_o);
    end
    next_cycle();
    rst_i = 1'b0;
    dmem_ready_i = 1'b1;
    nop();
  endtask

  task automatic test_reg_zero();
    do_reset();
    set_id(5'd1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // lw $0 (never a writer)
    next_cycle();
    set_id(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add $0,$0,$0
    next_cycle();
    set_id(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);   // beq $0,$0 not taken
    @(negedge clk);
    exp_v = 10'b0000000000;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL r0_no_stall: got %b want %b", obs, exp_v); end
    next_cycle();
    nop();
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL r0_no_fwd: got %b want %b", obs, exp_v); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_fwd_priority();
    test_branch_alu();
    test_branch_load();
    test_freeze();
    test_reset_mid_freeze();
    test_reg_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard, forwarding and pipeline-control block for the 5-stage MIPS core, replacing the separate `Forward` and `Hazard_Detection` units. It keeps a registered shadow of the destination-register state for the EX, MEM and WB stages and advances that shadow in lockstep with the pipeline registers. From the shadow it generates:
- EX-operand forward selects and ID-stage branch-compare forwarding;
- load-use and branch-in-ID stalls and control-bubble insertion;
- IF/ID flush;
- whole-pipeline freeze while a multi-cycle data memory is not ready.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, perf-counter width. Used only with HAZ_PERF_CNT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- id_rs_i  in  REG_AW  rs of the instruction in IF/ID.
- id_rt_i  in  REG_AW  rt of the instruction in IF/ID.
- id_dest_i  in  REG_AW  resolved destination of the ID instruction (after RegDst).
- id_regwrite_i / id_memread_i / id_memwrite_i  in  1 each  decoded controls of the ID instruction.
- id_branch_i  in  1  ID instruction compares rs/rt in ID (beq).
- id_taken_i  in  1  branch taken or jump, from the ID stage.
- dmem_ready_i  in  1  data memory has completed the MEM-stage access.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  zero the controls entering ID/EX.
- flush_o  out  1  clear IF/ID.
- freeze_o  out  1  hold every pipeline register.
- fwd_a_o / fwd_b_o  out  2 each  EX operand select: 00 register file, 01 WB result, 10 EX/MEM ALU result.
- fwd_id_a_o / fwd_id_b_o  out  1 each  select the EX/MEM ALU result for the ID branch compare.
- stall_cnt_o / flush_cnt_o / freeze_cnt_o  out  CNT_W each  perf counters.

## Operation
- Shadow entries:
  - EX, MEM and WB: valid, dest, regwrite, memread, memwrite.
  - EX additionally holds rs and rt.
- A "writer" is an entry with valid && regwrite && dest != 0. Register 0 never matches.
- Freeze:
  - freeze_o = MEM.valid && (MEM.memread || MEM.memwrite) && !dmem_ready_i.
  - While frozen, all shadow entries hold.
- Advance when freeze_o = 0:
  - WB <= MEM and MEM <= EX.
  - EX <= an invalid entry if bubble_o, otherwise the ID inputs.
- Load-use stall: the EX entry is a writer with memread, and its dest equals id_rs_i or id_rt_i.
- Branch stall (only when id_branch_i = 1), either of:
  - the EX entry is a writer and its dest equals rs or rt;
  - the MEM entry is a writer with memread and its dest equals rs or rt.
- stall_o = freeze_o || load-use stall || branch stall.
- bubble_o = !freeze_o && (load-use stall || branch stall).
- flush_o = id_taken_i && !stall_o. A taken branch held by a stall flushes only on the cycle it is accepted.
- EX forwarding, per operand, comparing EX.rs (EX.rt for operand b):
  - 10 if the MEM entry is a writer without memread and its dest matches;
  - otherwise 01 if the WB entry is a writer and its dest matches;
  - otherwise 00.
  - MEM has priority over WB.
- fwd_id_x_o = 1 when id_branch_i is set and the MEM entry is a non-load writer whose dest equals id_rs_i (a) or id_rt_i (b). A WB-stage match needs no forwarding because the register file is write-before-read.
- Simultaneous events:
  - freeze dominates stall; stall dominates flush.
  - bubble_o and flush_o are never both 1.

## Timing
- Shadow state is registered. All outputs are combinational from the shadow plus the current ID inputs and dmem_ready_i, so they are valid in the same cycle.
- Reset:
  - asserted at any time, it clears all valid bits and counters asynchronously;
  - while rst_i = 1, all outputs are 0;
  - after reset, the first clock loads the EX entry.
- A load-use stall lasts exactly 1 cycle.
- A branch depending on an ALU result in EX stalls 1 cycle. A branch depending on a load stalls 2 cycles, then forwards via WB through the register file.
- Freeze lasts as long as dmem_ready_i is low. No shadow entry is lost or duplicated.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cnt_o, flush_cnt_o and freeze_cnt_o increment on each cycle that stall_o, flush_o or freeze_o is 1, respectively;
  - they wrap modulo 2^CNT_W and reset to 0.
- HAZ_PERF_CNT_EN undefined: no counter flops; the three outputs are tied to 0.

## Test plan
- lw $2,0($1); add $3,$2,$4 → 1 cycle of stall_o=bubble_o=1, then fwd_a_o=01 for the add in EX.
- add $2,$1,$1; sub $3,$2,$2 → no stall; fwd_a_o=fwd_b_o=10 on the sub's EX cycle.
- add $2 then add $2 then or $5,$2,$0 → fwd_a_o=10 (MEM priority over WB).
- add $2,$1,$1; beq $2,$3 → 1 stall cycle, then fwd_id_a_o=1 with flush_o=id_taken_i.
- lw $2; beq $2,$2 → 2 stall cycles, then fwd_id_a_o=0 and flush_o=1.
- lw in MEM with dmem_ready_i low for 3 cycles → freeze_o=stall_o=1 for 3 cycles and shadow unchanged. With HAZ_PERF_CNT_EN, freeze_cnt_o=3. Asserting rst_i mid-freeze zeroes all outputs immediately.
- add $0,$1,$1; add $3,$0,$0 → no forwarding (fwd=00) and no stall.
